// File: rtl/key_pkg.sv
// Shared types and constants for the space-bar conditioning path.
//  key_state_e : debounce FSM state encoding
//  cnt_width() : counter width helper, never returns less than 1 bit
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_e;

    // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Auto-repeat is off unless the integrator asks for it
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 0;

    // Bits needed to hold 0..n, with a 1-bit floor so n==0 still yields a legal vector
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : key_pkg

// File: rtl/key_sync.sv
// Two-flop synchroniser for a single asynchronous bit.
//  clk   : destination clock
//  rst   : synchronous active-high reset, loads RST_VAL into both flops
//  i_d   : asynchronous input
//  o_q   : synchronised output, 2 cycles of latency
module key_sync
    import key_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : key_sync

// File: rtl/space_key_debounce.sv
// Space-bar conditioner: synchronise, debounce, then emit single-cycle strobes.
//  clk           : system clock
//  rst           : synchronous active-high reset
//  key_raw       : asynchronous raw key (active-low when KEY_ACTIVE_LOW=1)
//  key_level     : debounced pressed level
//  press_pulse   : 1-cycle strobe on accepted press
//  release_pulse : 1-cycle strobe on accepted release
//  repeat_pulse  : 1-cycle strobe every REPEAT_CYCLES while held (0 disables)
module space_key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W      = cnt_width(REPEAT_CYCLES);
    localparam int unsigned RPT_LAST_I = (REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0;
    localparam bit          RPT_EN     = (REPEAT_CYCLES > 0);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_LAST_I);

    // Raw pin value that means "not pressed"
    localparam logic RAW_RELEASED = KEY_ACTIVE_LOW;

    key_state_e       r_state;
    key_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;

    logic r_key_level;
    logic r_press;
    logic r_release;
    logic r_repeat;
    logic w_level_nxt;
    logic w_press_nxt;
    logic w_release_nxt;
    logic w_repeat_nxt;

    logic w_sync_q;
    logic w_key_s;
    logic w_cnt_done;
    logic w_rpt_done;

    // Synchroniser resets to the released level so reset never looks like a press
    key_sync #(
        .RST_VAL (RAW_RELEASED)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (key_raw),
        .o_q (w_sync_q)
    );

    // Normalise polarity: 1 = pressed from here on
    assign w_key_s = w_sync_q ^ KEY_ACTIVE_LOW;

    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_rpt_done = RPT_EN && (r_rpt == RPT_LAST);

    // State register plus all registered outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rpt       <= '0;
            r_key_level <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rpt       <= w_rpt_nxt;
            r_key_level <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_repeat    <= w_repeat_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_key_s) begin
                    w_state_nxt = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!w_key_s) begin
                    w_state_nxt = IDLE;
                end else if (w_cnt_done) begin
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (!w_key_s) begin
                    w_state_nxt = REL_CHK;
                end
            end
            REL_CHK: begin
                if (w_key_s) begin
                    w_state_nxt = HELD;
                end else if (w_cnt_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counter and output next values; pulses default low so each lasts one cycle
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_rpt_nxt     = r_rpt;
        w_level_nxt   = r_key_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_key_s) begin
                    w_cnt_nxt = '0;
                end
            end
            PRESS_CHK: begin
                if (!w_key_s) begin
                    w_cnt_nxt = r_cnt;
                end else if (w_cnt_done) begin
                    w_press_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                    w_rpt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!w_key_s) begin
                    w_cnt_nxt = '0;
                end else if (w_rpt_done) begin
                    w_repeat_nxt = 1'b1;
                    w_rpt_nxt    = '0;
                end else if (RPT_EN) begin
                    // Held at zero when auto-repeat is disabled so it cannot wrap
                    w_rpt_nxt = r_rpt + RPT_W'(1);
                end
            end
            REL_CHK: begin
                if (w_key_s) begin
                    // Rejected release restarts the repeat period
                    w_rpt_nxt = '0;
                end else if (w_cnt_done) begin
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt = '0;
                w_rpt_nxt = '0;
            end
        endcase
    end

    assign key_level     = r_key_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;

endmodule : space_key_debounce

// File: tb/tb_space_key_debounce.sv
// Self-checking bench for space_key_debounce (DEBOUNCE=4, REPEAT=6, active-low key).
module tb_space_key_debounce;
    import key_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned RPT = 6;

    logic clk;
    logic rst;
    logic key_raw;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    space_key_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (RPT),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_raw       (key_raw),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int n_press  = 0;
    int n_rel    = 0;
    int n_rep    = 0;
    int press_cyc = -1;
    int rel_cyc   = -1;

    // Reference model: raw samples pass through a 2-deep delay line, then the
    // accepted level flips once DEB+1 consecutive samples disagree with it.
    logic m_d1 = 1'b1;
    logic m_d2 = 1'b1;
    logic m_level = 1'b0;
    int   m_run = 0;
    int   m_rc  = 0;
    logic e_press = 1'b0;
    logic e_rel   = 1'b0;
    logic e_rpt   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    task automatic model_edge(input logic rs, input logic raw);
        logic ks;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_rpt   = 1'b0;
        if (rs) begin
            m_d1 = 1'b1;
            m_d2 = 1'b1;
            m_level = 1'b0;
            m_run = 0;
            m_rc  = 0;
            return;
        end
        ks   = ~m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        if (ks != m_level) begin
            m_run++;
            if (m_run == int'(DEB) + 1) begin
                m_level = ks;
                if (ks) e_press = 1'b1;
                else    e_rel   = 1'b1;
                m_run = 0;
                m_rc  = 0;
            end
        end else begin
            if (m_level) begin
                if (m_run > 0) begin
                    m_rc = 0;
                end else begin
                    m_rc++;
                    if (m_rc == int'(RPT)) begin
                        e_rpt = 1'b1;
                        m_rc  = 0;
                    end
                end
            end
            m_run = 0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later
    task automatic tick(input logic raw, input logic rs);
        key_raw = raw;
        rst     = rs;
        @(posedge clk);
        model_edge(rs, raw);
        cyc++;
        #1;
        check("key_level",     32'(key_level),     32'(m_level));
        check("press_pulse",   32'(press_pulse),   32'(e_press));
        check("release_pulse", 32'(release_pulse), 32'(e_rel));
        check("repeat_pulse",  32'(repeat_pulse),  32'(e_rpt));
        if (press_pulse === 1'b1)   begin n_press++; press_cyc = cyc; end
        if (release_pulse === 1'b1) begin n_rel++;   rel_cyc   = cyc; end
        if (repeat_pulse === 1'b1)  n_rep++;
    endtask

    initial begin
        int base_p;
        int base_r;
        int base_t;
        int f_edge;
        int r_edge;
        logic rv;
        logic rs;
        int len;

        key_raw = 1'b1;
        rst     = 1'b1;

        // Reset, then clean press sampled from edge 10
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
        check("t1_press_cycle", 32'(press_cyc), 32'd16);
        check("t1_press_count", 32'(n_press), 32'd1);
        check("t1_level", 32'(key_level), 32'd1);

        // Hold 30 cycles past acceptance: five repeats
        base_t = n_rep;
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
        check("t3_repeat_count", 32'(n_rep - base_t), 32'd5);

        // Release with bounce
        base_p = n_press;
        base_r = n_rel;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        f_edge = cyc + 1;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        check("t4_release_count", 32'(n_rel - base_r), 32'd1);
        check("t4_release_cycle", 32'(rel_cyc), 32'(f_edge + 6));
        check("t4_no_press", 32'(n_press - base_p), 32'd0);
        check("t4_level", 32'(key_level), 32'd0);

        // Glitch: two low cycles only
        base_p = n_press;
        base_r = n_rel;
        base_t = n_rep;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        check("t2_pulses", 32'((n_press - base_p) + (n_rel - base_r) + (n_rep - base_t)), 32'd0);
        check("t2_state_idle", 32'(dut.r_state), 32'(IDLE));

        // Reset mid-PRESS_CHK with cnt==2
        base_p = n_press;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        check("t5_state_chk", 32'(dut.r_state), 32'(PRESS_CHK));
        check("t5_cnt", 32'(dut.r_cnt), 32'd2);
        tick(1'b0, 1'b1);
        r_edge = cyc + 1;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("t5_press_count", 32'(n_press - base_p), 32'd1);
        check("t5_press_cycle", 32'(press_cyc), 32'(r_edge + 6));

        // Reset while HELD, key still pressed
        base_p = n_press;
        base_r = n_rel;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("t6_level_after_rst", 32'(key_level), 32'd0);
        check("t6_pulses_after_rst", 32'({press_pulse, release_pulse, repeat_pulse}), 32'd0);
        r_edge = cyc + 1;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("t6_no_release", 32'(n_rel - base_r), 32'd0);
        check("t6_press_count", 32'(n_press - base_p), 32'd1);
        check("t6_press_cycle", 32'(press_cyc), 32'(r_edge + 6));
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);

        // Random segments against the reference model
        for (int s = 0; s < 400; s++) begin
            rs = ($urandom_range(0, 49) == 0);
            rv = 1'($urandom_range(0, 1));
            if (rs)                               len = $urandom_range(1, 2);
            else if ($urandom_range(0, 4) == 0)   len = $urandom_range(6, 24);
            else                                  len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) tick(rv, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_space_key_debounce
